// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO: shift-add multiply, restoring divide,
// MTHI/MTLO moves. Valid/ready accept; busy until commit; cancel aborts with no HI/LO write.
module mul_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_FAST   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic                  cancel,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    op_q;
  logic          neg_q;
  logic          neg_r;
  logic [W-1:0]  a_raw;
  logic [W-1:0]  opnd;
  logic [W-1:0]  work_hi;
  logic [W-1:0]  work_lo;

  logic          is_signed;
  logic          sa;
  logic          sb;
  logic          short_op;
  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;

  always_comb begin
    is_signed = ~op[2] & ~op[0];
    sa        = is_signed & src_a[W-1];
    sb        = is_signed & src_b[W-1];
    a_mag     = sa ? -src_a : src_a;
    b_mag     = sb ? -src_b : src_b;
    short_op  = op[2] | (~op[1] & (MUL_FAST != 0));
  end

  // One iteration: multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
  logic [W:0]   mul_sum;
  logic [W:0]   div_shift;
  logic         div_ge;
  logic [W-1:0] step_hi;
  logic [W-1:0] step_lo;

  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    div_shift = {work_hi, work_lo[W-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    if (op_q[1]) begin
      step_hi = div_ge ? (div_shift[W-1:0] - opnd) : div_shift[W-1:0];
      step_lo = {work_lo[W-2:0], div_ge};
    end else begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], work_lo[W-1:1]};
    end
  end

  logic [2*W-1:0] mul_raw;
  logic [2*W-1:0] mul_res;
  logic [W-1:0]   res_hi;
  logic [W-1:0]   res_lo;

  always_comb begin
    mul_raw = (MUL_FAST != 0) ? ({{W{1'b0}}, opnd} * {{W{1'b0}}, work_lo})
                              : {step_hi, step_lo};
    mul_res = neg_q ? -mul_raw : mul_raw;
    res_hi  = hi;
    res_lo  = lo;
    case (op_q)
      3'b000, 3'b001: begin
        res_hi = mul_res[2*W-1:W];
        res_lo = mul_res[W-1:0];
      end
      3'b010, 3'b011: begin
        // Divide by zero returns all-ones quotient and the untouched dividend.
        if (opnd == '0) begin
          res_hi = a_raw;
          res_lo = '1;
        end else begin
          res_hi = neg_r ? -step_hi : step_hi;
          res_lo = neg_q ? -step_lo : step_lo;
        end
      end
      3'b100:  res_hi = a_raw;
      3'b101:  res_lo = a_raw;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      a_raw   <= '0;
      opnd    <= '0;
      work_hi <= '0;
      work_lo <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && !cancel) begin
            state   <= RUN;
            busy    <= 1'b1;
            op_q    <= op;
            a_raw   <= src_a;
            neg_q   <= sa ^ sb;
            neg_r   <= sa & op[1];
            cnt     <= short_op ? '0 : LAST;
            work_hi <= '0;
            if (op[1]) begin
              opnd    <= b_mag;
              work_lo <= a_mag;
            end else begin
              opnd    <= a_mag;
              work_lo <= b_mag;
            end
          end
        end
        RUN: begin
          if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            hi    <= res_hi;
            lo    <= res_lo;
            done  <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt     <= cnt - CW'(1);
            work_hi <= step_hi;
            work_lo <= step_lo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = ~busy;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: iterative and single-cycle multiply instances side by side.
module tb_mul_div_unit;
  localparam int W = 32;
  localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011;
  localparam logic [2:0] MTHI = 3'b100, MTLO = 3'b101, NOP = 3'b110;

  logic clk = 1'b0;
  logic rst, in_valid, cancel, use_f;
  logic [2:0] op;
  logic [W-1:0] src_a, src_b;

  logic valid_m, valid_f;
  logic ready_m, busy_m, done_m, ready_f, busy_f, done_f;
  logic [W-1:0] hi_m, lo_m, hi_f, lo_f;
  logic c_ready, c_busy, c_done;
  logic [W-1:0] c_hi, c_lo;

  assign valid_m = in_valid & ~use_f;
  assign valid_f = in_valid & use_f;
  assign c_ready = use_f ? ready_f : ready_m;
  assign c_busy  = use_f ? busy_f : busy_m;
  assign c_done  = use_f ? done_f : done_m;
  assign c_hi    = use_f ? hi_f : hi_m;
  assign c_lo    = use_f ? lo_f : lo_m;

  mul_div_unit #(.DATA_WIDTH(W), .MUL_FAST(0)) dut (
    .clk(clk), .rst(rst), .in_valid(valid_m), .in_ready(ready_m), .op(op),
    .src_a(src_a), .src_b(src_b), .cancel(cancel), .busy(busy_m), .done(done_m),
    .hi(hi_m), .lo(lo_m));

  mul_div_unit #(.DATA_WIDTH(W), .MUL_FAST(1)) dut_f (
    .clk(clk), .rst(rst), .in_valid(valid_f), .in_ready(ready_f), .op(op),
    .src_a(src_a), .src_b(src_b), .cancel(cancel), .busy(busy_f), .done(done_f),
    .hi(hi_f), .lo(lo_f));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; op = NOP; src_a = 32'hDEADBEEF; src_b = 32'h0BADF00D;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int lat,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int cyc = 0;
    int bcnt = 0;
    bit seen = 1'b0;
    issue(o, a, b);
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (c_done) begin
        seen = 1'b1;
        break;
      end
      cyc++;
      if (c_busy) bcnt++;
    end
    chk({tag, " done_seen"}, 64'(seen), 64'd1);
    chk({tag, " latency"}, 64'(cyc), 64'(lat));
    chk({tag, " busy_cycles"}, 64'(bcnt), 64'(lat));
    chk({tag, " hi"}, 64'(c_hi), 64'(ehi));
    chk({tag, " lo"}, 64'(c_lo), 64'(elo));
    chk({tag, " busy_at_done"}, 64'(c_busy), 64'd0);
    chk({tag, " ready_at_done"}, 64'(c_ready), 64'd1);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 64'(c_done), 64'd0);
  endtask

  initial begin
    int dcnt;
    rst = 1'b1; in_valid = 1'b0; cancel = 1'b0; use_f = 1'b0;
    op = NOP; src_a = '0; src_b = '0;
    #2;
    chk("rst busy", 64'(busy_m), 64'd0);
    chk("rst done", 64'(done_m), 64'd0);
    chk("rst hi", 64'(hi_m), 64'd0);
    chk("rst lo", 64'(lo_m), 64'd0);
    chk("rst ready", 64'(ready_m), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    run_op("mult_7x-6", MULT, 32'd7, 32'hFFFFFFFA, 32, 32'hFFFFFFFF, 32'hFFFFFFD6);
    run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_minxmin", MULT, 32'h80000000, 32'h80000000, 32, 32'h40000000, 32'h00000000);
    run_op("mult_minx1", MULT, 32'h80000000, 32'h00000001, 32, 32'hFFFFFFFF, 32'h80000000);
    run_op("div_-7/2", DIV, 32'hFFFFFFF9, 32'd2, 32, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_7/-2", DIV, 32'd7, 32'hFFFFFFFE, 32, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu_100/7", DIVU, 32'd100, 32'd7, 32, 32'd2, 32'd14);
    run_op("div_min/-1", DIV, 32'h80000000, 32'hFFFFFFFF, 32, 32'h00000000, 32'h80000000);
    run_op("divu_by0", DIVU, 32'd1234, 32'd0, 32, 32'h000004D2, 32'hFFFFFFFF);
    run_op("div_by0", DIV, 32'hFFFFFFFB, 32'd0, 32, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("nop", NOP, 32'h12345678, 32'h1, 1, 32'hFFFFFFFB, 32'hFFFFFFFF);

    use_f = 1'b1;
    run_op("fast_multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001);
    run_op("fast_mult_7x-6", MULT, 32'd7, 32'hFFFFFFFA, 1, 32'hFFFFFFFF, 32'hFFFFFFD6);
    run_op("fast_div_-7/2", DIV, 32'hFFFFFFF9, 32'd2, 32, 32'hFFFFFFFF, 32'hFFFFFFFD);
    use_f = 1'b0;

    // Cancel ten cycles into a divide.
    issue(DIV, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    chk("cancel busy_before", 64'(busy_m), 64'd1);
    cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    chk("cancel busy_after", 64'(busy_m), 64'd0);
    dcnt = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done_m) dcnt++;
    end
    chk("cancel no_done", 64'(dcnt), 64'd0);
    chk("cancel hi_kept", 64'(hi_m), 64'hFFFFFFFB);
    chk("cancel lo_kept", 64'(lo_m), 64'hFFFFFFFF);

    // Cancel landing exactly on the commit edge.
    issue(DIVU, 32'd100, 32'd7);
    repeat (W) @(negedge clk);
    chk("cancel_commit busy_before", 64'(busy_m), 64'd1);
    cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    chk("cancel_commit done", 64'(done_m), 64'd0);
    chk("cancel_commit busy", 64'(busy_m), 64'd0);
    chk("cancel_commit hi_kept", 64'(hi_m), 64'hFFFFFFFB);
    chk("cancel_commit lo_kept", 64'(lo_m), 64'hFFFFFFFF);

    // Cancel together with a request while idle.
    @(negedge clk);
    in_valid = 1'b1; op = MTHI; src_a = 32'h1234; cancel = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("idle_cancel no_accept", 64'(busy_m), 64'd0);
    @(negedge clk);
    chk("idle_cancel no_done", 64'(done_m), 64'd0);
    chk("idle_cancel hi_kept", 64'(hi_m), 64'hFFFFFFFB);

    // MTHI then MTLO with valid held high; second accept lands while done is high.
    @(negedge clk);
    in_valid = 1'b1; op = MTHI; src_a = 32'h0000AAAA;
    @(posedge clk);
    @(negedge clk);
    chk("mthi busy", 64'(busy_m), 64'd1);
    op = MTLO; src_a = 32'h00005555;
    @(negedge clk);
    chk("mthi done", 64'(done_m), 64'd1);
    chk("mthi hi", 64'(hi_m), 64'h0000AAAA);
    chk("mthi lo_kept", 64'(lo_m), 64'hFFFFFFFF);
    chk("mthi ready", 64'(ready_m), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("mtlo busy", 64'(busy_m), 64'd1);
    chk("mtlo done_low", 64'(done_m), 64'd0);
    @(negedge clk);
    chk("mtlo done", 64'(done_m), 64'd1);
    chk("mtlo hi", 64'(hi_m), 64'h0000AAAA);
    chk("mtlo lo", 64'(lo_m), 64'h00005555);

    // Asynchronous reset in the middle of a divide.
    issue(DIV, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    chk("rst_mid busy_before", 64'(busy_m), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid busy", 64'(busy_m), 64'd0);
    chk("rst_mid hi", 64'(hi_m), 64'd0);
    chk("rst_mid lo", 64'(lo_m), 64'd0);
    chk("rst_mid ready", 64'(ready_m), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid stays_idle", 64'(busy_m), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
